als_disp_ctrl: RTL and testbench
================================

# als_disp_ctrl

Update controller for the 4-digit seven-segment display on the ambient-light path. It accepts a binary light sample through a valid/ready handshake, saturates it to 9999, and converts it to four packed BCD digits with a sequential shift-add-3 (double-dabble) engine. It then holds the result for a programmable time so the display cannot flicker. `disp_data` connects directly to the 16-bit BCD input of the seg_display multiplexer.

## Interface
- `DATA_W`, 8: sample width in bits; legal range 4..14.
- `HOLD_CYC`, 10_000_000: minimum number of clock cycles between successive display updates; 0 is legal.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `smp_data` in DATA_W: unsigned binary light sample.
- `smp_valid` in 1: `smp_data` is valid.
- `smp_ready` out 1: block can accept a sample; registered.
- `disp_data` out 16: BCD digits. [15:12] is thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- `disp_upd` out 1: single-cycle pulse, high in the first cycle a new `disp_data` is presented.

## Operation
- **States:** IDLE, CONV, HOLD. The FSM, bit counter, hold counter and all outputs reset asynchronously.
- **Reset values:**
  - State is IDLE.
  - `smp_ready`, `disp_upd`, bit counter and hold counter are 0.
  - `disp_data` is 16'h0000.
- **IDLE:** on the first edge after reset release, `smp_ready` goes to 1. A transfer happens on an edge where `smp_valid` and `smp_ready` are both 1.
- **On transfer:**
  - Capture `sat = (smp_data > 9999) ? 9999 : smp_data` into the shift register.
  - Clear the BCD scratch register and clear the bit counter.
  - Set `smp_ready` to 0 and go to CONV.
- **CONV:** one iteration per cycle, exactly DATA_W iterations regardless of the value. Each iteration:
  - Add 3 to every scratch nibble that is ≥5.
  - Shift {scratch, shift} left by 1, MSB of the sample first.
- **End of conversion:** on the edge completing iteration DATA_W:
  - Load the scratch register into `disp_data` and set `disp_upd` to 1.
  - If HOLD_CYC > 0, go to HOLD and load the hold counter.
  - If HOLD_CYC = 0, go to IDLE and set `smp_ready` to 1.
- **HOLD:** stay for HOLD_CYC cycles with `smp_ready` at 0, then go to IDLE with `smp_ready` at 1.
- **Samples offered while `smp_ready` is 0:** not accepted. The block has no storage for them; holding or dropping them is the producer's choice.
- **`disp_upd`:** cleared on the edge after it is set.
- **`disp_data`:** changes only at end of conversion or on reset. Every nibble is always 0..9.
- **Reset mid-operation (CONV or HOLD):** the partial conversion is discarded, `disp_data` returns to 16'h0000, and the block restarts in IDLE.
- **Widths:**
  - Scratch register is 16 bits.
  - Bit counter is ceil(log2(DATA_W+1)) bits.
  - Hold counter is ceil(log2(HOLD_CYC+1)) bits, or a minimum of 1 bit.
  - The saturation compare is done at max(DATA_W, 14) bits. For DATA_W ≤ 13 the compare can never trigger except above 9999.

## Timing
- Call the transfer edge T.
- **CONV:** occupies the cycles after T; the bit counter runs 0..DATA_W-1.
- **Update:** `disp_data` and `disp_upd` change on edge T + DATA_W. This is a latency of DATA_W cycles from the transfer edge.
- **Ready returns:** `smp_ready` rises on edge T + DATA_W + HOLD_CYC.
  - With HOLD_CYC = 0, `smp_ready` and `disp_upd` are high in the same cycle.
  - A new transfer can then occur on edge T + DATA_W + 1.
- **Maximum sample rate:** one sample per DATA_W + HOLD_CYC + 1 cycles when HOLD_CYC > 0. With HOLD_CYC = 0 the rate is one per DATA_W + 1 cycles.
- **Valid/ready:** `smp_ready` does not depend combinationally on `smp_valid`.
- **Throttled source:** `smp_valid` may be held across many cycles. Only one transfer occurs per ready window.

## Test plan
- **Basic conversion:** DATA_W=8, HOLD_CYC=4; after reset, offer 255.
  - `disp_data` = 16'h0255 with a 1-cycle `disp_upd` on edge T+8.
  - `smp_ready` returns on edge T+12.
- **Reset and zero sample:** hold `rst_n` low.
  - While in reset: `disp_data` = 16'h0000, `smp_ready` = 0, `disp_upd` = 0.
  - After release: `smp_ready` = 1 one edge later.
  - Offer 0: `disp_data` stays 16'h0000 and `disp_upd` still pulses.
- **Saturation:** DATA_W=14.
  - Offer 12345: `disp_data` = 16'h9999.
  - Offer 9999: `disp_data` = 16'h9999.
  - Offer 1000: `disp_data` = 16'h1000.
- **Hold window:** HOLD_CYC=20; assert `smp_valid` continuously with a value changing every cycle.
  - Exactly one transfer per 8+20+1 cycles.
  - `disp_data` equals the BCD of the value present on each transfer edge.
  - No transfer occurs while `smp_ready` = 0.
- **Reset mid-conversion:** assert `rst_n` low at T+3 during CONV after a prior display of 16'h0128.
  - `disp_data` goes to 16'h0000 immediately; no `disp_upd`.
  - After release, the next sample converts normally.
- **Back-to-back:** HOLD_CYC=0; offer 7, then 99, then 100 back-to-back.
  - Successive updates 16'h0007, 16'h0099, 16'h0100.
  - Updates are spaced 9 cycles apart.

Source files
------------

// File: rtl/als_disp_ctrl.sv
// Ambient-light display update controller: saturates a binary sample to 9999, converts it
// to packed BCD with a serial double-dabble engine, then holds the result against flicker.
module als_disp_ctrl #(
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_valid,
  output logic              smp_ready,
  output logic [15:0]       disp_data,
  output logic              disp_upd
);

  localparam int CMP_W  = (DATA_W > 14) ? DATA_W : 14;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int HOLD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DATA_W-1:0]   shift_reg;
  logic [15:0]         scratch;
  logic [15:0]         scr_adj;
  logic [15:0]         scr_nxt;
  logic                xfer;

  // Compare is widened so an 8..13-bit sample can never spuriously clamp.
  function automatic logic [DATA_W-1:0] sat_9999(input logic [DATA_W-1:0] d);
    logic [CMP_W-1:0] wide;
    wide = CMP_W'(d);
    if (wide > CMP_W'(9999))
      return DATA_W'(9999);
    return d;
  endfunction

  function automatic logic [15:0] add3(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int n = 0; n < 4; n++)
      if (s[n*4 +: 4] >= 4'd5)
        r[n*4 +: 4] = s[n*4 +: 4] + 4'd3;
    return r;
  endfunction

  assign xfer    = (state == IDLE) && smp_ready && smp_valid;
  assign scr_adj = add3(scratch);
  assign scr_nxt = {scr_adj[14:0], shift_reg[DATA_W-1]};

  // Conversion datapath: no reset needed, it is reloaded on every transfer.
  always_ff @(posedge clk) begin
    if (xfer) begin
      shift_reg <= sat_9999(smp_data);
      scratch   <= '0;
    end else if (state == CONV) begin
      shift_reg <= shift_reg << 1;
      scratch   <= scr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      smp_ready <= 1'b0;
      disp_upd  <= 1'b0;
      disp_data <= 16'h0000;
      bit_cnt   <= '0;
      hold_cnt  <= '0;
    end else begin
      disp_upd <= 1'b0;
      case (state)
        IDLE: begin
          if (!smp_ready) begin
            smp_ready <= 1'b1;
          end else if (smp_valid) begin
            smp_ready <= 1'b0;
            bit_cnt   <= '0;
            state     <= CONV;
          end
        end
        CONV: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            disp_data <= scr_nxt;
            disp_upd  <= 1'b1;
            if (HOLD_CYC > 0) begin
              hold_cnt <= HOLD_LOAD;
              state    <= HOLD;
            end else begin
              smp_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            smp_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_als_disp_ctrl.sv
// Directed bench for als_disp_ctrl: four instances cover basic/reset, saturation,
// hold-window throttling and back-to-back operation against a BCD scoreboard.
module tb_als_disp_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  d0, d2, d3;
  logic [13:0] d1;
  logic [3:0]  sv;
  logic [3:0]  sr;
  logic [3:0]  du;
  logic [15:0] dd [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int upd_cnt [4] = '{0, 0, 0, 0};
  int upd_cyc [4] = '{0, 0, 0, 0};

  logic [15:0] q0[$], q1[$], q2[$], q3[$];

  als_disp_ctrl #(.DATA_W(8), .HOLD_CYC(4)) u0 (
    .clk(clk), .rst_n(rst_n), .smp_data(d0), .smp_valid(sv[0]),
    .smp_ready(sr[0]), .disp_data(dd[0]), .disp_upd(du[0]));
  als_disp_ctrl #(.DATA_W(14), .HOLD_CYC(0)) u1 (
    .clk(clk), .rst_n(rst_n), .smp_data(d1), .smp_valid(sv[1]),
    .smp_ready(sr[1]), .disp_data(dd[1]), .disp_upd(du[1]));
  als_disp_ctrl #(.DATA_W(8), .HOLD_CYC(20)) u2 (
    .clk(clk), .rst_n(rst_n), .smp_data(d2), .smp_valid(sv[2]),
    .smp_ready(sr[2]), .disp_data(dd[2]), .disp_upd(du[2]));
  als_disp_ctrl #(.DATA_W(8), .HOLD_CYC(0)) u3 (
    .clk(clk), .rst_n(rst_n), .smp_data(d3), .smp_valid(sv[3]),
    .smp_ready(sr[3]), .disp_data(dd[3]), .disp_upd(du[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic push(int i, logic [15:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic pop(int i, output logic [15:0] v);
    v = 16'hFFFF;
    case (i)
      0: if (q0.size() > 0) v = q0.pop_front();
      1: if (q1.size() > 0) v = q1.pop_front();
      2: if (q2.size() > 0) v = q2.pop_front();
      default: if (q3.size() > 0) v = q3.pop_front();
    endcase
  endtask

  function automatic int qsize(int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic set_in(int i, int v, logic vl);
    case (i)
      0: d0 = 8'(v);
      1: d1 = 14'(v);
      2: d2 = 8'(v);
      default: d3 = 8'(v);
    endcase
    sv[i] = vl;
  endtask

  // Offer one sample, waiting (bounded) for ready; returns the transfer edge index.
  task automatic offer(int i, int v, output int t);
    int n;
    n = 0;
    set_in(i, v, 1'b1);
    while (sr[i] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sr[i] === 1'b1) push(i, to_bcd(v));
    @(negedge clk);
    t = cyc;
    set_in(i, 0, 1'b0);
    chk("offer_accepted", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_ready(int i, output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      if (sr[i] === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    #1;
  endtask

  // Scoreboard: every update pulse pops the oldest expected display value.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        if (du[i] === 1'b1) begin
          pop(i, e);
          upd_cyc[i] = cyc;
          upd_cnt[i]++;
          chk($sformatf("disp%0d", i), 32'(dd[i]), 32'(e));
        end
      end
    end
  end

  initial begin
    int t, r, u_prev, cnt0, last, ntr, v;
    rst_n = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    sv = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_disp", 32'(dd[0]), 32'h0000);
    chk("rst_ready", 32'(sr[0]), 32'd0);
    chk("rst_upd", 32'(du[0]), 32'd0);
    chk("rst_ready_all", 32'(sr), 32'd0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(sr[0]), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(sr[0]), 32'd1);

    // Zero sample: display stays zero but still pulses
    cnt0 = upd_cnt[0];
    offer(0, 0, t);
    wait_ready(0, r);
    chk("zero_disp", 32'(dd[0]), 32'h0000);
    chk("zero_upd_cnt", 32'(upd_cnt[0]), 32'(cnt0 + 1));

    // Basic 255 with timing
    offer(0, 255, t);
    wait_ready(0, r);
    chk("basic_upd_edge", 32'(upd_cyc[0]), 32'(t + 8));
    chk("basic_ready_edge", 32'(r), 32'(t + 12));
    chk("basic_disp", 32'(dd[0]), 32'h0255);

    // Reset mid-conversion after a prior display of 128
    offer(0, 128, t);
    wait_ready(0, r);
    chk("pre_reset_disp", 32'(dd[0]), 32'h0128);
    offer(0, 77, t);
    @(negedge clk);
    @(negedge clk);
    cnt0 = upd_cnt[0];
    rst_n = 1'b0;
    #1;
    chk("midrst_disp", 32'(dd[0]), 32'h0000);
    chk("midrst_upd", 32'(du[0]), 32'd0);
    chk("midrst_ready", 32'(sr[0]), 32'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_upd", 32'(upd_cnt[0]), 32'(cnt0));
    chk("midrst_disp_held", 32'(dd[0]), 32'h0000);
    offer(0, 200, t);
    wait_ready(0, r);
    chk("post_rst_disp", 32'(dd[0]), 32'h0200);
    chk("post_rst_upd_cnt", 32'(upd_cnt[0]), 32'(cnt0 + 1));

    // Saturation, DATA_W=14, no hold
    offer(1, 12345, t);
    wait_ready(1, r);
    chk("sat_ready_edge", 32'(r), 32'(t + 14));
    chk("sat_upd_edge", 32'(upd_cyc[1]), 32'(t + 14));
    chk("sat_12345", 32'(dd[1]), 32'h9999);
    offer(1, 9999, t);
    wait_ready(1, r);
    chk("sat_9999", 32'(dd[1]), 32'h9999);
    offer(1, 1000, t);
    wait_ready(1, r);
    chk("sat_1000", 32'(dd[1]), 32'h1000);
    offer(1, 16383, t);
    wait_ready(1, r);
    chk("sat_16383", 32'(dd[1]), 32'h9999);
    offer(1, 10000, t);
    wait_ready(1, r);
    chk("sat_10000", 32'(dd[1]), 32'h9999);

    // Hold window: valid held, data changing every cycle
    cnt0 = upd_cnt[2];
    ntr = 0;
    last = -1;
    for (int k = 0; k < 100; k++) begin
      v = (k * 37 + 11) & 255;
      set_in(2, v, 1'b1);
      if (sr[2] === 1'b1) begin
        push(2, to_bcd(v));
        if (last >= 0) chk("hold_spacing", 32'(cyc + 1 - last), 32'd29);
        last = cyc + 1;
        ntr++;
      end
      @(negedge clk);
    end
    set_in(2, 0, 1'b0);
    wait_ready(2, r);
    chk("hold_transfers", 32'(ntr), 32'd4);
    chk("hold_upd_cnt", 32'(upd_cnt[2] - cnt0), 32'(ntr));

    // Back-to-back with no hold
    offer(3, 7, t);
    wait_ready(3, r);
    chk("b2b_upd0_edge", 32'(upd_cyc[3]), 32'(t + 8));
    chk("b2b_ready_with_upd", 32'(r), 32'(t + 8));
    u_prev = upd_cyc[3];
    offer(3, 99, t);
    wait_ready(3, r);
    chk("b2b_spacing1", 32'(upd_cyc[3] - u_prev), 32'd9);
    chk("b2b_disp99", 32'(dd[3]), 32'h0099);
    u_prev = upd_cyc[3];
    offer(3, 100, t);
    wait_ready(3, r);
    chk("b2b_spacing2", 32'(upd_cyc[3] - u_prev), 32'd9);
    chk("b2b_disp100", 32'(dd[3]), 32'h0100);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("sb_empty%0d", i), 32'(qsize(i)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
